dram_bank_ctrl: RTL and testbench

Parametrised second-generation DRAM controller core between the L2 request port and the DRAM bank model. It queues L2 read/write requests in a small FIFO, tracks the open row of every bank, and issues ACT/PRE/RD/WR commands over a four-phase cmd_req/cmd_ack handshake. Per-command timing gaps (tRCD, tRP) are enforced by a counter. Read data returns to L2 as a one-cycle response pulse.

---
 rtl/dram_bank_ctrl_if.sv | 42 ++++
 rtl/dram_bank_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_ctrl_if.sv
// L2 request/response and DRAM command bundle for dram_bank_ctrl.
// slave is the controller side; master is the L2 + DRAM model side.
interface dram_bank_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BANK_W     = 3,
    parameter int ROW_W      = 7,
    parameter int COL_W      = 3
);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    logic                  l2_req_valid;
    logic                  l2_req_ready;
    logic                  l2_req_rw;
    logic [ADDR_W-1:0]     l2_req_addr;
    logic [DATA_WIDTH-1:0] l2_req_data;
    logic                  l2_rsp_valid;
    logic [DATA_WIDTH-1:0] l2_rsp_data;
    logic                  cmd_req;
    logic                  cmd_ack;
    logic [1:0]            cmd;
    logic [BANK_W-1:0]     bank_id;
    logic [ROW_W-1:0]      row_id;
    logic [COL_W-1:0]      col_id;
    logic [DATA_WIDTH-1:0] dram_wdata;
    logic [DATA_WIDTH-1:0] dram_rdata;

    modport slave (
        input  l2_req_valid, l2_req_rw, l2_req_addr,
        input  l2_req_data, cmd_ack, dram_rdata,
        output l2_req_ready, l2_rsp_valid, l2_rsp_data,
        output cmd_req, cmd, bank_id, row_id, col_id,
        output dram_wdata
    );

    modport master (
        output l2_req_valid, l2_req_rw, l2_req_addr,
        output l2_req_data, cmd_ack, dram_rdata,
        input  l2_req_ready, l2_rsp_valid, l2_rsp_data,
        input  cmd_req, cmd, bank_id, row_id, col_id,
        input  dram_wdata
    );
endinterface

// File: rtl/dram_bank_ctrl.sv
// DRAM bank controller: request FIFO, open-row table, ACT/PRE/RD/WR sequencer.
// Define DRAM_CTRL_OPEN_PAGE_EN for open-page; default is closed-page.
module dram_bank_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int REQ_DEPTH    = 4,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2
) (
    input logic             clk,
    input logic             rst,
    dram_bank_ctrl_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int PTR_W  = $clog2(REQ_DEPTH);
    localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W  = $clog2(T_MAX + 2);

    typedef enum logic [1:0] {
        S_IDLE, S_REQ, S_REL, S_GAP
    } state_e;

    typedef enum logic [1:0] {
        CMD_ACT, CMD_PRE, CMD_RD, CMD_WR
    } cmd_e;

    logic                  r_fifo_rw   [REQ_DEPTH];
    logic [ADDR_W-1:0]     r_fifo_addr [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [REQ_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;

    logic [NUM_OF_BANKS-1:0] r_open_valid;
    logic [ROW_W-1:0]        r_open_row [NUM_OF_BANKS];

    state_e                r_state;
    cmd_e                  r_cmd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_auto;
    logic                  r_cur_rw;
    logic [BANK_W-1:0]     r_cur_bank;
    logic [ROW_W-1:0]      r_cur_row;
    logic [COL_W-1:0]      r_cur_col;
    logic [DATA_WIDTH-1:0] r_cur_data;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [BANK_W-1:0] w_head_bank;
    logic [ROW_W-1:0]  w_head_row;
    cmd_e             w_access;
    logic [CNT_W-1:0] w_gap;
    logic             w_ack_hs;
    state_e           w_state_nxt;
    cmd_e             w_cmd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_auto_nxt;

    assign w_full  = (r_count == (PTR_W+1)'(REQ_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.l2_req_valid && bus.l2_req_ready;

    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_bank = w_head_addr[ADDR_W-1 -: BANK_W];
    assign w_head_row  = w_head_addr[COL_W +: ROW_W];

    assign w_access = r_cur_rw ? CMD_WR : CMD_RD;
    assign w_ack_hs = (r_state == S_REQ) && bus.cmd_ack;
    assign w_gap    = (r_cmd == CMD_ACT) ? CNT_W'(T_RCD)
                                         : CNT_W'(T_RP);

    assign bus.l2_req_ready = !w_full && !rst;
    assign bus.l2_rsp_valid = r_rsp_valid;
    assign bus.l2_rsp_data  = r_rsp_data;
    assign bus.cmd_req      = (r_state == S_REQ);
    assign bus.cmd          = r_cmd;
    assign bus.bank_id      = r_cur_bank;
    assign bus.row_id       = r_cur_row;
    assign bus.col_id       = r_cur_col;
    assign bus.dram_wdata   = r_cur_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_auto_nxt  = r_auto;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_auto_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                    if (!r_open_valid[w_head_bank])
                        w_cmd_nxt = CMD_ACT;
                    else if (r_open_row[w_head_bank] == w_head_row)
                        w_cmd_nxt = r_fifo_rw[r_rptr] ? CMD_WR : CMD_RD;
                    else
                        w_cmd_nxt = CMD_PRE;
                end
            end
            S_REQ: begin
                if (bus.cmd_ack)
                    w_state_nxt = S_REL;
            end
            S_REL: begin
                if (!bus.cmd_ack) begin
                    unique case (r_cmd)
                        CMD_ACT, CMD_PRE: begin
                            if (r_cmd == CMD_ACT)
                                w_cmd_nxt = w_access;
                            else if (!r_auto)
                                w_cmd_nxt = CMD_ACT;
                            if (w_gap != '0) begin
                                w_state_nxt = S_GAP;
                                w_cnt_nxt   = w_gap - 1'b1;
                            end else begin
                                w_state_nxt = r_auto ? S_IDLE : S_REQ;
                            end
                        end
                        default: begin
`ifdef DRAM_CTRL_OPEN_PAGE_EN
                            w_state_nxt = S_IDLE;
`else
                            // close the row right after the access
                            w_cmd_nxt   = CMD_PRE;
                            w_auto_nxt  = 1'b1;
                            w_state_nxt = S_REQ;
`endif
                        end
                    endcase
                end
            end
            S_GAP: begin
                if (r_cnt == '0)
                    w_state_nxt = r_auto ? S_IDLE : S_REQ;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_ACT;
            r_cnt   <= '0;
            r_auto  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_auto  <= w_auto_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rw[r_wptr]   <= bus.l2_req_rw;
            r_fifo_addr[r_wptr] <= bus.l2_req_addr;
            r_fifo_data[r_wptr] <= bus.l2_req_data;
        end
        if (w_ack_hs && r_cmd == CMD_ACT)
            r_open_row[r_cur_bank] <= r_cur_row;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_rw     <= 1'b0;
            r_cur_bank   <= '0;
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_cur_data   <= '0;
            r_open_valid <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            if (w_pop) begin
                r_cur_rw   <= r_fifo_rw[r_rptr];
                r_cur_bank <= w_head_bank;
                r_cur_row  <= w_head_row;
                r_cur_col  <= w_head_addr[COL_W-1:0];
                r_cur_data <= r_fifo_data[r_rptr];
            end
            if (w_ack_hs && r_cmd == CMD_ACT)
                r_open_valid[r_cur_bank] <= 1'b1;
            if (w_ack_hs && r_cmd == CMD_PRE)
                r_open_valid[r_cur_bank] <= 1'b0;
            // REQ lasts until the first ack, so this fires once per RD
            r_rsp_valid <= w_ack_hs && (r_cmd == CMD_RD);
            if (w_ack_hs && r_cmd == CMD_RD)
                r_rsp_data <= bus.dram_rdata;
        end
    end
endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Self-checking bench for dram_bank_ctrl (both page policies).
// Commands and read data are checked against an in-order scoreboard.
module tb_dram_bank_ctrl;
    localparam int T_RCD = 2;

    typedef struct {
        logic       rw;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [1:0] cmd;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic [7:0] wdata;
    } ecmd_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    dram_bank_ctrl_if #(
        .DATA_WIDTH(8), .BANK_W(3), .ROW_W(7), .COL_W(3)
    ) bus ();

    dram_bank_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    ecmd_t      exp_cmds[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] mem [8192];
    logic [7:0] m_open;
    logic [6:0] m_row [8];
    logic       ack_en = 0;
    logic       ack_dly = 0;
    logic       seen = 0;
    logic       prev_ok = 0;
    logic [1:0] prev_cmd = 0;
    logic       prev_rsp = 0;
    int         idle_n = 0;
    vec_t       tbl [11];

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endfunction

    function automatic void add_cmd(logic [1:0] c, logic [2:0] b,
                                    logic [6:0] r, logic [2:0] co,
                                    logic [7:0] d);
        ecmd_t e;
        e.cmd = c; e.bank = b; e.row = r; e.col = co; e.wdata = d;
        exp_cmds.push_back(e);
    endfunction

    function automatic void model_push(logic rw, logic [2:0] b,
                                       logic [6:0] r, logic [2:0] c,
                                       logic [7:0] d, logic [7:0] x);
        logic [1:0] acc;
        acc = rw ? 2'b11 : 2'b10;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        if (m_open[b] && m_row[b] != r)
            add_cmd(2'b01, b, r, c, d);
        if (!m_open[b] || m_row[b] != r)
            add_cmd(2'b00, b, r, c, d);
        add_cmd(acc, b, r, c, d);
        m_open[b] = 1'b1;
        m_row[b]  = r;
`else
        add_cmd(2'b00, b, r, c, d);
        add_cmd(acc, b, r, c, d);
        add_cmd(2'b01, b, r, c, d);
`endif
        if (!rw) exp_rsp.push_back(x);
    endfunction

    task automatic push_req(input logic rw, input logic [2:0] b,
                            input logic [6:0] r, input logic [2:0] c,
                            input logic [7:0] d, input logic [7:0] x);
        int n = 0;
        bus.l2_req_valid = 1'b1;
        bus.l2_req_rw    = rw;
        bus.l2_req_addr  = {b, r, c};
        bus.l2_req_data  = d;
        while (!bus.l2_req_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.l2_req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: ready got 0 required 1");
        end else begin
            @(posedge clk);
            model_push(rw, b, r, c, d, x);
            #1;
        end
        bus.l2_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_cmds.size() != 0 || exp_rsp.size() != 0)
               && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("drain_left", exp_cmds.size() + exp_rsp.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    // DRAM-side monitor, memory model and ack responder
    always @(negedge clk) begin
        ecmd_t e;
        if (rst) begin
            seen = 0; prev_ok = 0; idle_n = 0; prev_rsp = 0;
        end else begin
            if (bus.cmd_req && !seen) begin
                seen = 1;
                if (prev_ok && prev_cmd == 2'b00)
                    chk("trcd_gap", idle_n, T_RCD);
                if (exp_cmds.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_cmd: got %0d required none",
                             bus.cmd);
                end else begin
                    e = exp_cmds.pop_front();
                    chk("cmd", bus.cmd, e.cmd);
                    chk("bank_id", bus.bank_id, e.bank);
                    if (e.cmd != 2'b01)
                        chk("row_id", bus.row_id, e.row);
                    if (e.cmd[1])
                        chk("col_id", bus.col_id, e.col);
                    if (e.cmd == 2'b11)
                        chk("dram_wdata", bus.dram_wdata, e.wdata);
                end
                if (bus.cmd == 2'b11)
                    mem[{bus.bank_id, bus.row_id, bus.col_id}] =
                        bus.dram_wdata;
                if (bus.cmd == 2'b10)
                    bus.dram_rdata =
                        mem[{bus.bank_id, bus.row_id, bus.col_id}];
                prev_cmd = bus.cmd;
                prev_ok  = 1;
            end
            if (!bus.cmd_req) seen = 0;
            if (!bus.cmd_req && !bus.cmd_ack) idle_n++;
            else idle_n = 0;
            if (bus.l2_rsp_valid) begin
                chk("rsp_pulse_len", prev_rsp, 0);
                if (exp_rsp.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got %0h required none",
                             bus.l2_rsp_data);
                end else begin
                    chk("rsp_data", bus.l2_rsp_data, exp_rsp.pop_front());
                end
            end
            prev_rsp = bus.l2_rsp_valid;
        end
        if (!ack_en) begin
            bus.cmd_ack = 0; ack_dly = 0;
        end else if (bus.cmd_req && !bus.cmd_ack) begin
            if (ack_dly) begin bus.cmd_ack = 1; ack_dly = 0; end
            else ack_dly = 1;
        end else if (!bus.cmd_req && bus.cmd_ack) begin
            bus.cmd_ack = 0;
        end
    end

    initial begin
        int cnt;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        m_open = '0;
        for (int i = 0; i < 8; i++) m_row[i] = '0;
        tbl[0]  = '{1'b1, 3'd3, 7'd5,   3'd2, 8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 3'd3, 7'd5,   3'd2, 8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 3'd3, 7'd9,   3'd1, 8'h3C, 8'h00};
        tbl[3]  = '{1'b0, 3'd3, 7'd9,   3'd1, 8'h00, 8'h3C};
        tbl[4]  = '{1'b0, 3'd3, 7'd5,   3'd2, 8'h00, 8'hA5};
        tbl[5]  = '{1'b1, 3'd0, 7'd1,   3'd7, 8'hFF, 8'h00};
        tbl[6]  = '{1'b0, 3'd0, 7'd1,   3'd7, 8'h00, 8'hFF};
        tbl[7]  = '{1'b0, 3'd0, 7'd1,   3'd7, 8'h00, 8'hFF};
        tbl[8]  = '{1'b1, 3'd7, 7'd127, 3'd7, 8'h5A, 8'h00};
        tbl[9]  = '{1'b0, 3'd7, 7'd127, 3'd7, 8'h00, 8'h5A};
        tbl[10] = '{1'b0, 3'd3, 7'd5,   3'd2, 8'h00, 8'hA5};

        bus.l2_req_valid = 1'b1;
        bus.l2_req_rw    = 1'b1;
        bus.l2_req_addr  = 13'h1234;
        bus.l2_req_data  = 8'h77;
        bus.cmd_ack      = 1'b0;
        bus.dram_rdata   = 8'h00;

        // reset held 3 cycles with a request pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", bus.l2_req_ready, 0);
            chk("rst_cmd_req", bus.cmd_req, 0);
            chk("rst_rsp_valid", bus.l2_rsp_valid, 0);
        end
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_addr", {bus.bank_id, bus.row_id, bus.col_id}, 0);
        chk("rst_wdata", bus.dram_wdata, 0);
        chk("rst_rsp_data", bus.l2_rsp_data, 0);
        rst = 0;
        bus.l2_req_valid = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cmd_req) cnt++;
        end
        chk("empty_after_rst", cnt, 0);
        chk("ready_after_rst", bus.l2_req_ready, 1);

        ack_en = 1;
        foreach (tbl[i])
            push_req(tbl[i].rw, tbl[i].bank, tbl[i].row,
                     tbl[i].col, tbl[i].data, tbl[i].exp_rd);
        wait_drain();

        // FIFO full: one request in flight, four queued
        ack_en = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            push_req(1'b1, 3'd2, 7'd3, 3'(i), 8'(8'h10 + i), 8'h00);
        chk("ready_full", bus.l2_req_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("ready_held", bus.l2_req_ready, 0);
        end
        ack_en = 1;
        push_req(1'b1, 3'd2, 7'd3, 3'd5, 8'h15, 8'h00);
        push_req(1'b0, 3'd2, 7'd3, 3'd4, 8'h00, 8'h14);
        wait_drain();

        // reset while an ACT is being requested
        ack_en = 0;
        @(negedge clk);
        push_req(1'b0, 3'd5, 7'd0, 3'd0, 8'h00, 8'h00);
        push_req(1'b0, 3'd3, 7'd5, 3'd2, 8'h00, 8'hA5);
        cnt = 0;
        while (!bus.cmd_req && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        chk("req_before_rst", bus.cmd_req, 1);
        chk("act_before_rst", bus.cmd, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_cmd_req", bus.cmd_req, 0);
        chk("rst_mid_ready", bus.l2_req_ready, 0);
        exp_cmds.delete();
        exp_rsp.delete();
        m_open = '0;
        @(negedge clk);
        rst = 0;
        ack_en = 1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cmd_req || bus.l2_rsp_valid) cnt++;
        end
        chk("dropped_after_rst", cnt, 0);
        push_req(1'b0, 3'd3, 7'd5, 3'd2, 8'h00, 8'hA5);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
